// File: rtl/ysyx_2022040010_mem_arbiter.sv
// ysyx_2022040010_mem_arbiter
// Shares the single-ported core memory bus between instruction fetch (IF)
// and the load/store unit (LS). LS has fixed priority, one transaction is
// outstanding at a time, and responses are routed back to the transaction
// owner with no added latency. IF responses made stale by a branch flush
// are swallowed through the drop flag.
// Optional feature macro: YSYX_2022040010_MEM_ARB_TIMEOUT_EN
//   defined   -> TMO_W-bit response timeout with sticky arb_timeout flag
//   undefined -> WAIT states wait indefinitely, arb_timeout tied low
module ysyx_2022040010_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int TMO_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_W-1:0]     ls_addr,
  input  logic [DATA_W-1:0]     ls_wdata,
  input  logic [DATA_W/8-1:0]   ls_wmask,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [DATA_W-1:0]     ls_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wmask,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stallreq_for_if,
  output logic                  stallreq_for_ls,
  output logic                  arb_timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IF = 2'd1,
    WAIT_LS = 2'd2
  } state_t;

  state_t              state;
  logic                drop;
  logic                sel_ls;
  logic                sel_if;
  logic                accept;
  logic                tmo_hit;
  logic                done;
  logic [DATA_W-1:0]   resp_data;

  // A zero-width timeout counter is meaningless; reject it at elaboration.
  if (TMO_W < 1) begin : g_tmo_w_check
    $error("TMO_W must be at least 1");
  end

  // Requester selection: LS wins; IF is never offered while a flush is active.
  always_comb begin
    sel_ls = 1'b0;
    sel_if = 1'b0;
    case (state)
      IDLE: begin
        if (ls_req) begin
          sel_ls = 1'b1;
        end else if (if_req && !flush) begin
          sel_if = 1'b1;
        end else begin
          sel_ls = 1'b0;
        end
      end
      default: begin
        sel_ls = 1'b0;
        sel_if = 1'b0;
      end
    endcase
  end

  // Memory request mux; the bus is quiet whenever nothing is selected.
  always_comb begin
    mem_req   = sel_ls | sel_if;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (sel_ls) begin
      mem_we    = ls_we;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_wmask = ls_wmask;
    end else if (sel_if) begin
      mem_addr  = if_addr;
    end else begin
      mem_we    = 1'b0;
    end
  end

  assign accept = mem_req & mem_ready;
  assign if_gnt = sel_if & mem_ready;
  assign ls_gnt = sel_ls & mem_ready;

  // Completion: real response, or (timeout build) a forced empty response.
  always_comb begin
    done      = 1'b0;
    resp_data = '0;
    if ((state == WAIT_IF) || (state == WAIT_LS)) begin
      done = mem_rvalid | tmo_hit;
      if (mem_rvalid) begin
        resp_data = mem_rdata;
      end else begin
        resp_data = '0;
      end
    end else begin
      done = 1'b0;
    end
  end

  // Response routing; a flushed or pending-drop IF response never surfaces.
  always_comb begin
    if_rvalid = (state == WAIT_IF) & done & ~drop & ~flush;
    ls_rvalid = (state == WAIT_LS) & done;
    if (if_rvalid) begin
      if_rdata = resp_data;
    end else begin
      if_rdata = '0;
    end
    if (ls_rvalid) begin
      ls_rdata = resp_data;
    end else begin
      ls_rdata = '0;
    end
  end

  assign stallreq_for_if = if_req & ~if_rvalid & ~flush;
  assign stallreq_for_ls = ls_req & ~ls_rvalid;

  // Transaction FSM with the stale-fetch drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      drop  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (sel_ls) begin
              state <= WAIT_LS;
            end else begin
              state <= WAIT_IF;
              drop  <= flush;
            end
          end
        end
        WAIT_IF: begin
          if (done) begin
            state <= IDLE;
            drop  <= 1'b0;
          end else if (flush) begin
            drop  <= 1'b1;
          end
        end
        WAIT_LS: begin
          if (done) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          drop  <= 1'b0;
        end
      endcase
    end
  end

`ifdef YSYX_2022040010_MEM_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_flag;

  assign tmo_hit     = ((state == WAIT_IF) || (state == WAIT_LS)) & ~mem_rvalid
                       & (tmo_cnt == {TMO_W{1'b1}});
  assign arb_timeout = tmo_flag;

  // Counts silent WAIT cycles; held at zero in IDLE so each WAIT starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt  <= '0;
      tmo_flag <= 1'b0;
    end else begin
      if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (!mem_rvalid) begin
        tmo_cnt <= tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
      end
      if (tmo_hit) begin
        tmo_flag <= 1'b1;
      end
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_2022040010_mem_arbiter.sv
// Directed bench for ysyx_2022040010_mem_arbiter. The bench plays the memory;
// expected responses are queued when the memory response is driven and
// popped when the arbiter routes a response back.
module tb_ysyx_2022040010_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, flush, if_req, ls_req, ls_we;
  logic [31:0] if_addr, ls_addr, mem_addr;
  logic [63:0] ls_wdata, if_rdata, ls_rdata, mem_wdata, mem_rdata;
  logic [7:0]  ls_wmask, mem_wmask;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic        stallreq_for_if, stallreq_for_ls, arb_timeout;

  typedef struct {
    bit          is_ls;
    logic [63:0] data;
  } resp_t;
  resp_t sb[$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_2022040010_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_wmask(ls_wmask), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stallreq_for_if(stallreq_for_if),
    .stallreq_for_ls(stallreq_for_ls), .arb_timeout(arb_timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle, well clear of any clock edge.
  task automatic settle();
    #3;
  endtask

  // Compare the routed response (or its absence) against the scoreboard.
  task automatic resp_check(input string tag);
    resp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_none"}, {62'd0, if_rvalid, ls_rvalid}, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ls_rvalid"}, {63'd0, ls_rvalid}, {63'd0, e.is_ls});
      chk({tag, "_if_rvalid"}, {63'd0, if_rvalid}, {63'd0, !e.is_ls});
      chk({tag, "_rdata"}, e.is_ls ? ls_rdata : if_rdata, e.data);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {54'd0, mem_req, mem_we, if_gnt, ls_gnt, if_rvalid, ls_rvalid,
        stallreq_for_if, stallreq_for_ls, arb_timeout, 1'b0}, 64'd0);
    chk({tag, "_addr"}, {32'd0, mem_addr}, 64'd0);
    chk({tag, "_data"}, mem_wdata | if_rdata | ls_rdata | {56'd0, mem_wmask}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = 32'd0; ls_addr = 32'd0; ls_wdata = 64'd0; ls_wmask = 8'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 64'd0;
    settle();
    chk_all_zero("reset");
    nxt();
    rst_n = 1'b1;
    nxt();

    // Collision: LS wins, IF waits and is granted two cycles later.
    if_req = 1'b1; if_addr = 32'h8000_0000;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h8000_1000; mem_ready = 1'b1;
    settle();
    chk("col_mem_req", {63'd0, mem_req}, 64'd1);
    chk("col_mem_addr", {32'd0, mem_addr}, 64'h8000_1000);
    chk("col_gnts", {62'd0, ls_gnt, if_gnt}, 64'd2);
    chk("col_stall_if0", {63'd0, stallreq_for_if}, 64'd1);
    chk("col_stall_ls0", {63'd0, stallreq_for_ls}, 64'd1);
    nxt();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_DEAD_BEEF;
    sb.push_back('{1'b1, 64'h0000_0000_DEAD_BEEF});
    settle();
    resp_check("col_ls");
    chk("col_wait_mem_req", {63'd0, mem_req}, 64'd0);
    chk("col_stall_if1", {63'd0, stallreq_for_if}, 64'd1);
    chk("col_stall_ls1", {63'd0, stallreq_for_ls}, 64'd0);
    nxt();
    ls_req = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b1;
    settle();
    chk("col_if_gnt", {63'd0, if_gnt}, 64'd1);
    chk("col_if_addr", {32'd0, mem_addr}, 64'h8000_0000);
    chk("col_stall_if2", {63'd0, stallreq_for_if}, 64'd1);
    nxt();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    sb.push_back('{1'b0, 64'h0123_4567_89AB_CDEF});
    settle();
    resp_check("col_if");
    chk("col_stall_if3", {63'd0, stallreq_for_if}, 64'd0);
    nxt();
    if_req = 1'b0; mem_rvalid = 1'b0;

    // Flush during fetch: stale response dropped, redirected fetch served.
    if_req = 1'b1; if_addr = 32'h8000_0008; mem_ready = 1'b1;
    settle();
    chk("fl_gnt", {63'd0, if_gnt}, 64'd1);
    nxt();
    mem_ready = 1'b0; flush = 1'b1;
    settle();
    chk("fl_stall_if", {63'd0, stallreq_for_if}, 64'd0);
    chk("fl_mem_req", {63'd0, mem_req}, 64'd0);
    nxt();
    flush = 1'b0; if_addr = 32'h8000_0100;
    nxt();
    nxt();
    mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_0BAD_F00D;
    settle();
    resp_check("fl_stale");
    nxt();
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    settle();
    chk("fl_regnt", {63'd0, if_gnt}, 64'd1);
    chk("fl_readdr", {32'd0, mem_addr}, 64'h8000_0100);
    nxt();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_CAFE_0001;
    sb.push_back('{1'b0, 64'h0000_0000_CAFE_0001});
    settle();
    resp_check("fl_new");
    nxt();
    if_req = 1'b0; mem_rvalid = 1'b0;

    // Store with memory acceptance delayed two cycles.
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h8000_2000;
    ls_wdata = 64'h1122_3344_5566_7788; ls_wmask = 8'h0F; mem_ready = 1'b0;
    settle();
    chk("st_mem_req", {62'd0, mem_req, mem_we}, 64'd3);
    chk("st_addr", {32'd0, mem_addr}, 64'h8000_2000);
    chk("st_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    chk("st_wmask", {56'd0, mem_wmask}, 64'h0F);
    chk("st_nogrant0", {63'd0, ls_gnt}, 64'd0);
    nxt();
    settle();
    chk("st_nogrant1", {63'd0, ls_gnt}, 64'd0);
    nxt();
    mem_ready = 1'b1;
    settle();
    chk("st_gnt", {63'd0, ls_gnt}, 64'd1);
    nxt();
    mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'd0;
    sb.push_back('{1'b1, 64'd0});
    settle();
    resp_check("st_ack");
    nxt();
    ls_req = 1'b0; ls_we = 1'b0; ls_wmask = 8'd0; ls_wdata = 64'd0; mem_rvalid = 1'b0;

    // Reset in the middle of WAIT_LS abandons the transaction.
    ls_req = 1'b1; ls_addr = 32'h8000_3000; mem_ready = 1'b1;
    settle();
    chk("rs_gnt", {63'd0, ls_gnt}, 64'd1);
    nxt();
    mem_ready = 1'b0; ls_req = 1'b0; ls_addr = 32'd0; rst_n = 1'b0;
    settle();
    chk_all_zero("rs_mid");
    nxt();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 64'h55;
    settle();
    resp_check("rs_late");
    chk("rs_idle_mem_req", {63'd0, mem_req}, 64'd0);
    nxt();
    mem_rvalid = 1'b0;

`ifdef YSYX_2022040010_MEM_ARB_TIMEOUT_EN
    // Timeout: memory never answers a load.
    begin
      bit seen = 1'b0;
      ls_req = 1'b1; ls_addr = 32'h8000_4000; mem_ready = 1'b1;
      settle();
      chk("to_gnt", {63'd0, ls_gnt}, 64'd1);
      nxt();
      mem_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
        settle();
        if (ls_rvalid) begin
          seen = 1'b1;
          break;
        end
        nxt();
      end
      chk("to_rvalid", {63'd0, seen}, 64'd1);
      chk("to_rdata", ls_rdata, 64'd0);
      nxt();
      ls_req = 1'b0;
      settle();
      chk("to_flag", {63'd0, arb_timeout}, 64'd1);
      nxt();
      settle();
      chk("to_sticky", {63'd0, arb_timeout}, 64'd1);
    end
`else
    settle();
    chk("no_timeout_flag", {63'd0, arb_timeout}, 64'd0);
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
